fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register that sit directly upstream of the decode stage.
- Holds the PC and issues 16-bit instruction fetches to instruction memory over a ready handshake.
- Presents the registered instruction and PC+2 to decode.
- Supports decode-requested stalls, control-flow redirects from later stages, HALT detection, and a fetch-timeout error.

---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch bus between the fetch stage and imem.
// The fetch stage is the master; instruction memory is the slave.
interface fetch_stage_if;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_rdy;
  logic [15:0] imem_rdata;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdy,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdy,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register: PC, stall,
// redirect, HALT detection and a sticky fetch-timeout error.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter int          TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_stage_if.master        imem,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [15:0]          redirect_pc,
  output logic [15:0]          instr,
  output logic [15:0]          pc_plus2,
  output logic                 valid,
  output logic                 halted,
  output logic                 err
);

  typedef enum logic {FETCH, HALTED} state_t;

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] instr_n, pc_plus2_n;
  logic        valid_n, err_n;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] pc_inc;

  assign pc_inc         = pc + 16'd2;
  assign imem.imem_addr = pc;
  assign imem.imem_req  = (state == FETCH) & ~stall & ~redirect;
  assign halted         = (state == HALTED);

  // Next-state and IF/ID update, redirect > stall > fetch > halted.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instr_n    = instr;
    pc_plus2_n = pc_plus2;
    valid_n    = valid;
    cnt_n      = cnt;
    err_n      = err;
    if (redirect) begin
      pc_n    = {redirect_pc[15:1], 1'b0};
      instr_n = NOP_INSTR;
      valid_n = 1'b0;
      state_n = FETCH;
      cnt_n   = 8'd0;
      if (redirect_pc[0]) err_n = 1'b1;
    end else if (stall) begin
      state_n = state;
    end else if (state == FETCH) begin
      if (imem.imem_rdy) begin
        instr_n    = imem.imem_rdata;
        pc_plus2_n = pc_inc;
        valid_n    = 1'b1;
        cnt_n      = 8'd0;
        if (imem.imem_rdata[15:11] == 5'b00000) state_n = HALTED;
        else                                    pc_n    = pc_inc;
      end else begin
        instr_n = NOP_INSTR;
        valid_n = 1'b0;
        if (cnt >= CNT_MAX) err_n = 1'b1;
        else                cnt_n = cnt + 8'd1;
      end
    end else begin
      instr_n = NOP_INSTR;
      valid_n = 1'b0;
    end
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      instr    <= NOP_INSTR;
      pc_plus2 <= 16'h0000;
      valid    <= 1'b0;
      cnt      <= 8'd0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      instr    <= instr_n;
      pc_plus2 <= pc_plus2_n;
      valid    <= valid_n;
      cnt      <= cnt_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stream, stall, halt,
// redirect, timeout, PC wrap and asynchronous reset.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr, pc_plus2;
  logic        valid, halted, err;
  logic [15:0] instr2, pc_plus22;
  logic        valid2, halted2, err2;

  int total;
  int bad;

  fetch_stage_if bus ();
  fetch_stage_if bus2 ();

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus.master),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .pc_plus2    (pc_plus2),
    .valid       (valid),
    .halted      (halted),
    .err         (err)
  );

  fetch_stage #(.RESET_PC(16'hFFFE)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus2.master),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr2),
    .pc_plus2    (pc_plus22),
    .valid       (valid2),
    .halted      (halted2),
    .err         (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic feed(input logic rdy, input logic [15:0] data);
    bus.imem_rdy    = rdy;
    bus.imem_rdata  = data;
    bus2.imem_rdy   = rdy;
    bus2.imem_rdata = data;
  endtask

  task automatic chk_ifid(input string tag,
                          input logic [15:0] ei,
                          input logic [15:0] ep,
                          input logic ev);
    chk({tag, ".instr"}, instr, ei);
    chk({tag, ".pc2"}, pc_plus2, ep);
    chk({tag, ".valid"}, {15'd0, valid}, {15'd0, ev});
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    feed(1'b0, 16'h0000);

    #12;
    chk_ifid("rst", 16'h0800, 16'h0000, 1'b0);
    chk("rst.halted", {15'd0, halted}, 16'd0);
    chk("rst.err", {15'd0, err}, 16'd0);
    chk("rst.addr", bus.imem_addr, 16'h0000);
    chk("rst.addr2", bus2.imem_addr, 16'hFFFE);

    // Straight-line stream.
    @(negedge clk);
    rst = 1'b1;
    feed(1'b1, 16'h4000);
    #1;
    chk("s0.req", {15'd0, bus.imem_req}, 16'd1);
    chk("s0.addr", bus.imem_addr, 16'h0000);
    tick();
    chk_ifid("s0", 16'h4000, 16'h0002, 1'b1);
    chk("s1.addr", bus.imem_addr, 16'h0002);
    chk("wrap.addr2", bus2.imem_addr, 16'h0000);
    chk("wrap.pc2", pc_plus22, 16'h0000);
    feed(1'b1, 16'h4100);
    tick();
    chk_ifid("s1", 16'h4100, 16'h0004, 1'b1);
    chk("s2.addr", bus.imem_addr, 16'h0004);
    feed(1'b1, 16'h4200);
    tick();
    chk_ifid("s2", 16'h4200, 16'h0006, 1'b1);
    chk("s3.addr", bus.imem_addr, 16'h0006);

    // Three-cycle decode stall.
    stall = 1'b1;
    feed(1'b1, 16'h4300);
    #1;
    chk("st.req", {15'd0, bus.imem_req}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ifid("st", 16'h4200, 16'h0006, 1'b1);
      chk("st.addr", bus.imem_addr, 16'h0006);
    end
    stall = 1'b0;
    tick();
    chk_ifid("st.out", 16'h4300, 16'h0008, 1'b1);
    chk("st.addr2", bus.imem_addr, 16'h0008);

    // Redirect to 0x10, then HALT there.
    redirect    = 1'b1;
    redirect_pc = 16'h0010;
    tick();
    chk_ifid("rd10", 16'h0800, 16'h0008, 1'b0);
    chk("rd10.addr", bus.imem_addr, 16'h0010);
    redirect = 1'b0;
    feed(1'b1, 16'h0000);
    tick();
    chk_ifid("halt", 16'h0000, 16'h0012, 1'b1);
    chk("halt.h", {15'd0, halted}, 16'd1);
    chk("halt.req", {15'd0, bus.imem_req}, 16'd0);
    chk("halt.addr", bus.imem_addr, 16'h0010);
    feed(1'b1, 16'h4400);
    tick();
    chk_ifid("halt2", 16'h0800, 16'h0012, 1'b0);
    chk("halt2.addr", bus.imem_addr, 16'h0010);
    chk("halt2.h", {15'd0, halted}, 16'd1);
    redirect    = 1'b1;
    redirect_pc = 16'h0020;
    tick();
    chk("rd20.h", {15'd0, halted}, 16'd0);
    chk("rd20.addr", bus.imem_addr, 16'h0020);
    redirect = 1'b0;
    feed(1'b1, 16'h4800);
    tick();
    chk_ifid("rd20", 16'h4800, 16'h0022, 1'b1);
    chk("rd20.addr2", bus.imem_addr, 16'h0022);

    // TIMEOUT-1 un-ready cycles: no error.
    feed(1'b0, 16'h4900);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to15.valid", {15'd0, valid}, 16'd0);
    end
    chk("to15.err", {15'd0, err}, 16'd0);
    feed(1'b1, 16'h4900);
    tick();
    chk_ifid("to15.out", 16'h4900, 16'h0024, 1'b1);
    chk("to15.err2", {15'd0, err}, 16'd0);

    // TIMEOUT un-ready cycles: error.
    feed(1'b0, 16'h4A00);
    for (int i = 0; i < 15; i++) tick();
    chk("to16.pre", {15'd0, err}, 16'd0);
    tick();
    chk("to16.err", {15'd0, err}, 16'd1);
    chk("to16.addr", bus.imem_addr, 16'h0024);

    // Asynchronous reset mid-stream.
    feed(1'b1, 16'h4B00);
    #3;
    rst = 1'b0;
    #1;
    chk_ifid("arst", 16'h0800, 16'h0000, 1'b0);
    chk("arst.err", {15'd0, err}, 16'd0);
    chk("arst.addr", bus.imem_addr, 16'h0000);
    chk("arst.addr2", bus2.imem_addr, 16'hFFFE);
    @(negedge clk);
    rst = 1'b1;

    // Redirect with stall to an odd target.
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0031;
    tick();
    chk_ifid("odd", 16'h0800, 16'h0000, 1'b0);
    chk("odd.addr", bus.imem_addr, 16'h0030);
    chk("odd.err", {15'd0, err}, 16'd1);
    redirect = 1'b0;
    stall    = 1'b0;
    feed(1'b1, 16'h4C00);
    tick();
    chk_ifid("odd2", 16'h4C00, 16'h0032, 1'b1);
    chk("odd2.err", {15'd0, err}, 16'd1);
    tick();
    chk("odd3.err", {15'd0, err}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
